// File: rtl/oled_pkg.sv
// Shared raster geometry, RGB565 colours and sequencer states for the OLED streamer.
// Constants and one pure function only: no latency, no flow control.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = 6144;
  localparam int PIX_IDX_W   = 13;
  localparam int COL_W       = 7;

  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SHIFT,
    GAP
  } state_t;

  // Eight vertical bars, 12 columns each, left to right.
  function automatic logic [15:0] test_bar_color(input logic [COL_W-1:0] col);
    logic [2:0]  bar;
    logic [15:0] color;
    bar = 3'(col / COL_W'(12));
    case (bar)
      3'd0:    color = WHITE;
      3'd1:    color = YELLOW;
      3'd2:    color = CYAN;
      3'd3:    color = GREEN;
      3'd4:    color = MAGENTA;
      3'd5:    color = RED;
      3'd6:    color = BLUE;
      default: color = BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/oled_spi_shift16.sv
// Serialises one 16-bit word MSB-first, mode 3 (sclk idles high, sdin changes on the falling edge).
// Latency: sclk falls the cycle after start, done pulses in the last of 32*CLK_DIV cycles; no backpressure, start while busy restarts.
module oled_spi_shift16 #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sclk,
  output logic        sdin,
  output logic        done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active;
  logic             high_half;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [14:0]      shreg;
  logic             half_end;

  assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done     = active && high_half && half_end && (bit_cnt == 4'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      high_half <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
      sclk      <= 1'b1;
      sdin      <= 1'b0;
    end else if (start) begin
      // MSB goes out with the first falling edge; the rest waits in shreg.
      active    <= 1'b1;
      high_half <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= 4'd15;
      shreg     <= word[14:0];
      sclk      <= 1'b0;
      sdin      <= word[15];
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!high_half) begin
          high_half <= 1'b1;
          sclk      <= 1'b1;
        end else if (bit_cnt == 4'd0) begin
          active    <= 1'b0;
          high_half <= 1'b0;
        end else begin
          high_half <= 1'b0;
          sclk      <= 1'b0;
          sdin      <= shreg[14];
          shreg     <= {shreg[13:0], 1'b0};
          bit_cnt   <= bit_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans the OLED raster, captures oled_data DATA_LAT cycles after each index and streams it over SPI; OLED_TEST_PATTERN_EN adds colour bars.
// Pixel period 1+DATA_LAT+32*CLK_DIV cycles, frame gap FRAME_GAP; no backpressure, the pixel source must meet DATA_LAT.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH     = OLED_WIDTH,
  parameter int HEIGHT    = OLED_PIXELS / OLED_WIDTH,
  parameter int CLK_DIV   = 2,
  parameter int DATA_LAT  = 1,
  parameter int FRAME_GAP = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [15:0]          oled_data,
`ifdef OLED_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic [PIX_IDX_W-1:0] pixel_index,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 sdin,
  output logic                 dc,
  output logic                 frame_begin,
  output logic                 sending_pixels
);

  localparam int                   NPIX     = WIDTH * HEIGHT;
  localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(NPIX - 1);
  localparam int                   GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  state_t               state_q, state_d;
  logic [PIX_IDX_W-1:0] idx_q, idx_d;
  logic [1:0]           wait_q, wait_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 start;
  logic                 done;
  logic                 in_frame_d;
  logic [15:0]          word;

  assign dc          = 1'b1;
  assign pixel_index = idx_q;

`ifdef OLED_TEST_PATTERN_EN
  // Column tracked alongside the index so the bar lookup needs no modulo.
  logic [COL_W-1:0] col_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
    end else if (idx_d == '0) begin
      col_q <= '0;
    end else if (idx_d != idx_q) begin
      col_q <= (col_q == COL_W'(WIDTH - 1)) ? '0 : col_q + 1'b1;
    end
  end

  assign word = test_mode ? test_bar_color(col_q) : oled_data;
`else
  assign word = oled_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (DATA_LAT == 0) begin
          start   = 1'b1;
          state_d = SHIFT;
        end else begin
          wait_d  = 2'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Capture happens on the edge that ends the last wait cycle.
        if (wait_q == 2'(DATA_LAT - 1)) begin
          start   = 1'b1;
          state_d = SHIFT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      SHIFT: begin
        if (done) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end else begin
            idx_d   = '0;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(FRAME_GAP - 1)) begin
          state_d = enable ? LOAD : IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_frame_d = (state_d == LOAD) || (state_d == WAIT) || (state_d == SHIFT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      wait_q         <= 2'd0;
      gap_q          <= '0;
      cs_n           <= 1'b1;
      sending_pixels <= 1'b0;
      frame_begin    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      gap_q          <= gap_d;
      cs_n           <= !in_frame_d;
      sending_pixels <= in_frame_d;
      frame_begin    <= (state_d == LOAD) && (idx_d == '0);
    end
  end

  oled_spi_shift16 #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .word   (word),
    .sclk   (sclk),
    .sdin   (sdin),
    .done   (done)
  );

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench: default DUT, a small-raster DUT for whole-frame checks and a CLK_DIV=1/DATA_LAT=0 DUT.
// Serial words are reassembled from sclk rising edges and compared against hand-computed values.
module tb_oled_pixel_streamer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Main DUT: default parameters.
  logic        enable_m = 1'b0, mode_m = 1'b0;
  logic [15:0] data_m = 16'h0;
  logic [12:0] pix_m;
  logic        cs_n_m, sclk_m, sdin_m, dc_m, fb_m, sp_m;
  // Small raster DUT: 8x4, default timing.
  logic        enable_s = 1'b0;
  logic [15:0] data_s = 16'h0;
  logic [12:0] pix_s;
  logic        cs_n_s, sclk_s, sdin_s, dc_s, fb_s, sp_s;
  // Fast DUT: 8x2, CLK_DIV=1, DATA_LAT=0.
  logic        enable_f = 1'b0;
  logic [15:0] data_f;
  logic [12:0] pix_f;
  logic        cs_n_f, sclk_f, sdin_f, dc_f, fb_f, sp_f;
`ifdef OLED_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
  logic        tm_off = 1'b0;
`endif

  // Pixel sources: one-cycle registered lookup, and a zero-latency one for the fast DUT.
  always @(posedge clock) begin
    data_m <= mode_m ? {3'b000, pix_m} : 16'hF800;
    data_s <= {3'b000, pix_s};
  end
  assign data_f = {3'b000, pix_f} ^ 16'h5A5A;

  oled_pixel_streamer dut_m (
    .clock(clock), .reset_n(reset_n), .enable(enable_m), .oled_data(data_m),
`ifdef OLED_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pixel_index(pix_m), .cs_n(cs_n_m), .sclk(sclk_m), .sdin(sdin_m), .dc(dc_m),
    .frame_begin(fb_m), .sending_pixels(sp_m)
  );

  oled_pixel_streamer #(.WIDTH(8), .HEIGHT(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .enable(enable_s), .oled_data(data_s),
`ifdef OLED_TEST_PATTERN_EN
    .test_mode(tm_off),
`endif
    .pixel_index(pix_s), .cs_n(cs_n_s), .sclk(sclk_s), .sdin(sdin_s), .dc(dc_s),
    .frame_begin(fb_s), .sending_pixels(sp_s)
  );

  oled_pixel_streamer #(.WIDTH(8), .HEIGHT(2), .CLK_DIV(1), .DATA_LAT(0), .FRAME_GAP(4)) dut_f (
    .clock(clock), .reset_n(reset_n), .enable(enable_f), .oled_data(data_f),
`ifdef OLED_TEST_PATTERN_EN
    .test_mode(tm_off),
`endif
    .pixel_index(pix_f), .cs_n(cs_n_f), .sclk(sclk_f), .sdin(sdin_f), .dc(dc_f),
    .frame_begin(fb_f), .sending_pixels(sp_f)
  );

  // Panel-side receivers: sample sdin on sclk rising edges, 16 bits per word.
  logic [15:0] sh_m = 16'h0, sh_s = 16'h0, sh_f = 16'h0;
  int          nb_m = 0, nb_s = 0, nb_f = 0;
  logic [15:0] q_m[$];
  logic [15:0] q_s[$];
  logic [15:0] q_f[$];

  always @(posedge sclk_m or negedge reset_n) begin
    if (!reset_n) nb_m = 0;
    else begin
      sh_m = {sh_m[14:0], sdin_m};
      nb_m++;
      if (nb_m == 16) begin q_m.push_back(sh_m); nb_m = 0; end
    end
  end
  always @(posedge sclk_s or negedge reset_n) begin
    if (!reset_n) nb_s = 0;
    else begin
      sh_s = {sh_s[14:0], sdin_s};
      nb_s++;
      if (nb_s == 16) begin q_s.push_back(sh_s); nb_s = 0; end
    end
  end
  always @(posedge sclk_f or negedge reset_n) begin
    if (!reset_n) nb_f = 0;
    else begin
      sh_f = {sh_f[14:0], sdin_f};
      nb_f++;
      if (nb_f == 16) begin q_f.push_back(sh_f); nb_f = 0; end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (pix_m !== 13'd0) begin errors++; $display("FAIL reset_pix got %0d want 0", pix_m); end
    checks++; if (cs_n_m !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n_m); end
    checks++; if (sclk_m !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", sclk_m); end
    checks++; if (sdin_m !== 1'b0) begin errors++; $display("FAIL reset_sdin got %b want 0", sdin_m); end
    checks++; if (dc_m !== 1'b1) begin errors++; $display("FAIL reset_dc got %b want 1", dc_m); end
    checks++; if (fb_m !== 1'b0) begin errors++; $display("FAIL reset_frame_begin got %b want 0", fb_m); end
    checks++; if (sp_m !== 1'b0) begin errors++; $display("FAIL reset_sending got %b want 0", sp_m); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cs_n_m !== 1'b1) begin errors++; $display("FAIL idle_cs_n got %b want 1", cs_n_m); end
  endtask

  task automatic test_first_pixel();
    int t0, t1;
    bit found;
    q_m.delete();
    enable_m = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (fb_m === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL first_frame_begin timeout got 0 want 1"); end
    t0 = cyc;
    checks++; if (cs_n_m !== 1'b0) begin errors++; $display("FAIL load_cs_n got %b want 0", cs_n_m); end
    checks++; if (pix_m !== 13'd0) begin errors++; $display("FAIL load_pix got %0d want 0", pix_m); end
    checks++; if (sp_m !== 1'b1) begin errors++; $display("FAIL load_sending got %b want 1", sp_m); end
    @(negedge clock);
    checks++; if (fb_m !== 1'b0) begin errors++; $display("FAIL fb_pulse_width got %b want 0", fb_m); end
    checks++; if (sclk_m !== 1'b1) begin errors++; $display("FAIL wait_sclk got %b want 1", sclk_m); end
    @(negedge clock);
    checks++; if (sclk_m !== 1'b0) begin errors++; $display("FAIL bit15_sclk_low got %b want 0", sclk_m); end
    checks++; if (sdin_m !== 1'b1) begin errors++; $display("FAIL bit15_sdin got %b want 1", sdin_m); end
    repeat (2) @(negedge clock);
    checks++; if (sclk_m !== 1'b1) begin errors++; $display("FAIL bit15_sclk_high got %b want 1", sclk_m); end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (pix_m === 13'd1) found = 1'b1;
    end
    t1 = cyc;
    checks++; if (!found || (t1 - t0) != 66) begin errors++; $display("FAIL pixel_period got %0d want 66", t1 - t0); end
    checks++;
    if (q_m.size() != 1) begin errors++; $display("FAIL word0_count got %0d want 1", q_m.size()); end
    else if (q_m[0] !== 16'hF800) begin errors++; $display("FAIL word0 got %h want f800", q_m[0]); end
    mode_m = 1'b1;
    q_m.delete();
  endtask

  task automatic test_reset_mid_bit();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clock);
      if (pix_m === 13'd50) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_pixel50 timeout got %0d want 50", pix_m); end
    repeat (35) @(negedge clock);
    checks++;
    if (q_m.size() != 49) begin errors++; $display("FAIL words_1_49_count got %0d want 49", q_m.size()); end
    else if (q_m[0] !== 16'd1 || q_m[48] !== 16'd49) begin
      errors++; $display("FAIL words_1_49 got %h..%h want 0001..0031", q_m[0], q_m[48]);
    end
    checks++; if (sclk_m !== 1'b0) begin errors++; $display("FAIL bit7_sclk_low got %b want 0", sclk_m); end
    reset_n = 1'b0;
    #1;
    checks++; if (pix_m !== 13'd0) begin errors++; $display("FAIL async_pix got %0d want 0", pix_m); end
    checks++; if (cs_n_m !== 1'b1) begin errors++; $display("FAIL async_cs_n got %b want 1", cs_n_m); end
    checks++; if (sclk_m !== 1'b1) begin errors++; $display("FAIL async_sclk got %b want 1", sclk_m); end
    checks++; if (sdin_m !== 1'b0) begin errors++; $display("FAIL async_sdin got %b want 0", sdin_m); end
    checks++; if (sp_m !== 1'b0) begin errors++; $display("FAIL async_sending got %b want 0", sp_m); end
    repeat (2) @(negedge clock);
    q_m.delete();
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (fb_m === 1'b1) found = 1'b1;
    end
    checks++; if (!found || pix_m !== 13'd0) begin errors++; $display("FAIL restart_frame got pix %0d want 0", pix_m); end
    for (int i = 0; i < 100 && q_m.size() == 0; i++) @(negedge clock);
    checks++;
    if (q_m.size() == 0) begin errors++; $display("FAIL restart_word timeout got none want 0000"); end
    else if (q_m[0] !== 16'h0000) begin errors++; $display("FAIL restart_word got %h want 0000", q_m[0]); end
  endtask

  task automatic test_fast();
    int t0, t1;
    bit found;
    q_f.delete();
    enable_f = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (fb_f === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL fast_frame_begin timeout got 0 want 1"); end
    t0 = cyc;
    @(negedge clock);
    checks++; if (sclk_f !== 1'b0 || sdin_f !== 1'b0) begin errors++; $display("FAIL fast_bit15 got sclk %b sdin %b want 0 0", sclk_f, sdin_f); end
    @(negedge clock);
    checks++; if (sclk_f !== 1'b1) begin errors++; $display("FAIL fast_half_period got sclk %b want 1", sclk_f); end
    @(negedge clock);
    checks++; if (sclk_f !== 1'b0 || sdin_f !== 1'b1) begin errors++; $display("FAIL fast_bit14 got sclk %b sdin %b want 0 1", sclk_f, sdin_f); end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (pix_f === 13'd1) found = 1'b1;
    end
    t1 = cyc;
    checks++; if (!found || (t1 - t0) != 33) begin errors++; $display("FAIL fast_pixel_period got %0d want 33", t1 - t0); end
    for (int i = 0; i < 200 && q_f.size() < 3; i++) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q_f.size() <= k) begin errors++; $display("FAIL fast_word%0d missing got %0d words", k, q_f.size()); end
      else if (q_f[k] !== (16'(k) ^ 16'h5A5A)) begin errors++; $display("FAIL fast_word%0d got %h want %h", k, q_f[k], 16'(k) ^ 16'h5A5A); end
    end
    enable_f = 1'b0;
  endtask

  task automatic test_full_frame();
    int  t0, t1, gap;
    bit  found;
    q_s.delete();
    enable_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (fb_s === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL small_frame_begin timeout got 0 want 1"); end
    t0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 2200 && !found; i++) begin
      @(negedge clock);
      if (cs_n_s === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL frame_end timeout got cs_n 0 want 1"); end
    checks++; if (pix_s !== 13'd0 || sp_s !== 1'b0) begin errors++; $display("FAIL gap_state got pix %0d sending %b want 0 0", pix_s, sp_s); end
    checks++; if (q_s.size() != 32) begin errors++; $display("FAIL frame_word_count got %0d want 32", q_s.size()); end
    for (int k = 0; k < 32 && k < q_s.size(); k++) begin
      checks++;
      if (q_s[k] !== 16'(k)) begin errors++; $display("FAIL frame_word%0d got %h want %h", k, q_s[k], 16'(k)); end
    end
    gap = 1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (cs_n_s === 1'b0) found = 1'b1;
      else gap++;
    end
    checks++; if (!found || gap != 16) begin errors++; $display("FAIL gap_length got %0d want 16", gap); end
    t1 = cyc;
    checks++; if (fb_s !== 1'b1) begin errors++; $display("FAIL second_frame_begin got %b want 1", fb_s); end
    checks++; if ((t1 - t0) != 2128) begin errors++; $display("FAIL frame_period got %0d want 2128", t1 - t0); end
    q_s.delete();
  endtask

  task automatic test_enable_drop();
    bit found;
    int fb_seen, low_seen;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clock);
      if (pix_s === 13'd15) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_pixel15 timeout got %0d want 15", pix_s); end
    enable_s = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clock);
      if (cs_n_s === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL drop_frame_end timeout got cs_n 0 want 1"); end
    checks++;
    if (q_s.size() != 32) begin errors++; $display("FAIL drop_word_count got %0d want 32", q_s.size()); end
    else if (q_s[15] !== 16'd15 || q_s[31] !== 16'd31) begin
      errors++; $display("FAIL drop_words got %h %h want 000f 001f", q_s[15], q_s[31]);
    end
    fb_seen = 0;
    low_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (fb_s !== 1'b0) fb_seen++;
      if (cs_n_s !== 1'b1) low_seen++;
    end
    checks++; if (fb_seen != 0) begin errors++; $display("FAIL no_new_frame got %0d pulses want 0", fb_seen); end
    checks++; if (low_seen != 0) begin errors++; $display("FAIL cs_n_idle got %0d low cycles want 0", low_seen); end
    checks++; if (pix_s !== 13'd0 || sp_s !== 1'b0) begin errors++; $display("FAIL idle_state got pix %0d sending %b want 0 0", pix_s, sp_s); end
  endtask

`ifdef OLED_TEST_PATTERN_EN
  task automatic test_pattern();
    reset_n = 1'b0;
    test_mode = 1'b1;
    repeat (2) @(negedge clock);
    q_m.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 7000 && q_m.size() < 96; i++) @(negedge clock);
    checks++;
    if (q_m.size() < 96) begin errors++; $display("FAIL pattern_words got %0d want 96", q_m.size()); end
    else begin
      if (q_m[0] !== 16'hFFFF || q_m[11] !== 16'hFFFF) begin errors++; $display("FAIL bar_white got %h %h want ffff", q_m[0], q_m[11]); end
      checks++; if (q_m[12] !== 16'hFFE0) begin errors++; $display("FAIL bar_yellow got %h want ffe0", q_m[12]); end
      checks++; if (q_m[24] !== 16'h07FF) begin errors++; $display("FAIL bar_cyan got %h want 07ff", q_m[24]); end
      checks++; if (q_m[60] !== 16'hF800) begin errors++; $display("FAIL bar_red got %h want f800", q_m[60]); end
      checks++; if (q_m[95] !== 16'h0000) begin errors++; $display("FAIL bar_black got %h want 0000", q_m[95]); end
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_pixel();
    test_reset_mid_bit();
    test_fast();
    test_full_frame();
    test_enable_drop();
`ifdef OLED_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
